// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported word memory between instruction fetch
// (port 0, read-only) and load/store (port 1, read/write); one access in flight at a time.
module mem_arbiter #(
   parameter int FIXED_PRIORITY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic [31:0] p0_addr,
   output logic        p0_done,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_done,
   output logic [31:0] p1_rdata,
   output logic [31:0] m_in_addr,
   output logic [31:0] m_in_data,
   output logic        m_in_valid,
   input  logic        m_in_ready,
   output logic [31:0] m_out_addr,
   output logic        m_out_valid,
   input  logic [31:0] m_out_data,
   input  logic        m_out_ready
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic        last_grant_q, last_grant_d;
   logic        m_in_valid_q, m_in_valid_d;
   logic        m_out_valid_q, m_out_valid_d;
   logic        p0_done_q, p0_done_d;
   logic        p1_done_q, p1_done_d;
   logic [31:0] m_in_addr_q, m_in_addr_d;
   logic [31:0] m_in_data_q, m_in_data_d;
   logic [31:0] m_out_addr_q, m_out_addr_d;
   logic [31:0] p0_rdata_q, p0_rdata_d;
   logic [31:0] p1_rdata_q, p1_rdata_d;

   logic        elig0, elig1, pick, ready_hit;

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      we_d          = we_q;
      last_grant_d  = last_grant_q;
      m_in_valid_d  = m_in_valid_q;
      m_out_valid_d = m_out_valid_q;
      p0_done_d     = 1'b0;
      p1_done_d     = 1'b0;
      m_in_addr_d   = m_in_addr_q;
      m_in_data_d   = m_in_data_q;
      m_out_addr_d  = m_out_addr_q;
      p0_rdata_d    = p0_rdata_q;
      p1_rdata_d    = p1_rdata_q;

      // A port whose done is high this cycle still shows its old req; mask it once.
      elig0 = p0_req && !p0_done_q;
      elig1 = p1_req && !p1_done_q;
      if (elig0 && elig1) begin
         pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
      end else begin
         pick = elig1;
      end
      ready_hit = we_q ? m_in_ready : m_out_ready;

      case (state_q)
         IDLE: begin
            if (elig0 || elig1) begin
               gnt_d        = pick;
               last_grant_d = pick;
               state_d      = BUSY;
               if (pick && p1_we) begin
                  we_d         = 1'b1;
                  m_in_addr_d  = p1_addr;
                  m_in_data_d  = p1_wdata;
                  m_in_valid_d = 1'b1;
               end else begin
                  we_d          = 1'b0;
                  m_out_addr_d  = pick ? p1_addr : p0_addr;
                  m_out_valid_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (ready_hit) begin
               m_in_valid_d  = 1'b0;
               m_out_valid_d = 1'b0;
               state_d       = IDLE;
               if (gnt_q) begin
                  p1_done_d = 1'b1;
                  if (!we_q) p1_rdata_d = m_out_data;
               end else begin
                  p0_done_d  = 1'b1;
                  p0_rdata_d = m_out_data;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         gnt_q         <= 1'b0;
         we_q          <= 1'b0;
         last_grant_q  <= 1'b1;
         m_in_valid_q  <= 1'b0;
         m_out_valid_q <= 1'b0;
         p0_done_q     <= 1'b0;
         p1_done_q     <= 1'b0;
         m_in_addr_q   <= '0;
         m_in_data_q   <= '0;
         m_out_addr_q  <= '0;
         p0_rdata_q    <= '0;
         p1_rdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         we_q          <= we_d;
         last_grant_q  <= last_grant_d;
         m_in_valid_q  <= m_in_valid_d;
         m_out_valid_q <= m_out_valid_d;
         p0_done_q     <= p0_done_d;
         p1_done_q     <= p1_done_d;
         m_in_addr_q   <= m_in_addr_d;
         m_in_data_q   <= m_in_data_d;
         m_out_addr_q  <= m_out_addr_d;
         p0_rdata_q    <= p0_rdata_d;
         p1_rdata_q    <= p1_rdata_d;
      end
   end

   assign p0_done     = p0_done_q;
   assign p0_rdata    = p0_rdata_q;
   assign p1_done     = p1_done_q;
   assign p1_rdata    = p1_rdata_q;
   assign m_in_addr   = m_in_addr_q;
   assign m_in_data   = m_in_data_q;
   assign m_in_valid  = m_in_valid_q;
   assign m_out_addr  = m_out_addr_q;
   assign m_out_valid = m_out_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (a_*) and a fixed-priority
// instance (b_*), each against a memory that pulses ready one cycle after seeing valid.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrors = 0;

   // Instance A: FIXED_PRIORITY = 0
   logic        a_p0_req, a_p0_done, a_p1_req, a_p1_we, a_p1_done;
   logic [31:0] a_p0_addr, a_p0_rdata, a_p1_addr, a_p1_wdata, a_p1_rdata;
   logic [31:0] a_m_in_addr, a_m_in_data, a_m_out_addr, a_m_out_data;
   logic        a_m_in_valid, a_m_out_valid, a_in_ready, a_out_ready;

   // Instance B: FIXED_PRIORITY = 1
   logic        b_p0_req, b_p0_done, b_p1_req, b_p1_we, b_p1_done;
   logic [31:0] b_p0_addr, b_p0_rdata, b_p1_addr, b_p1_wdata, b_p1_rdata;
   logic [31:0] b_m_in_addr, b_m_in_data, b_m_out_addr, b_m_out_data;
   logic        b_m_in_valid, b_m_out_valid, b_in_ready, b_out_ready;

   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_data;
   logic [31:0] mem_a [0:63];
   int          a_rd_cnt = 0;
   int          a_wr_cnt = 0;

   mem_arbiter #(.FIXED_PRIORITY(0)) dut_a (
      .clk(clk), .reset(reset),
      .p0_req(a_p0_req), .p0_addr(a_p0_addr), .p0_done(a_p0_done), .p0_rdata(a_p0_rdata),
      .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
      .p1_done(a_p1_done), .p1_rdata(a_p1_rdata),
      .m_in_addr(a_m_in_addr), .m_in_data(a_m_in_data), .m_in_valid(a_m_in_valid),
      .m_in_ready(a_in_ready),
      .m_out_addr(a_m_out_addr), .m_out_valid(a_m_out_valid), .m_out_data(a_m_out_data),
      .m_out_ready(a_out_ready)
   );

   mem_arbiter #(.FIXED_PRIORITY(1)) dut_b (
      .clk(clk), .reset(reset),
      .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
      .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
      .p1_done(b_p1_done), .p1_rdata(b_p1_rdata),
      .m_in_addr(b_m_in_addr), .m_in_data(b_m_in_data), .m_in_valid(b_m_in_valid),
      .m_in_ready(b_in_ready),
      .m_out_addr(b_m_out_addr), .m_out_valid(b_m_out_valid), .m_out_data(b_m_out_data),
      .m_out_ready(b_out_ready)
   );

   // Memory model: ready pulses the cycle after valid is seen; access happens on valid&&ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_in_ready  <= 1'b0;
         a_out_ready <= 1'b0;
         b_in_ready  <= 1'b0;
         b_out_ready <= 1'b0;
      end else begin
         a_in_ready  <= a_m_in_valid && !a_in_ready;
         a_out_ready <= a_m_out_valid && !a_out_ready;
         b_in_ready  <= b_m_in_valid && !b_in_ready;
         b_out_ready <= b_m_out_valid && !b_out_ready;
         if (a_m_in_valid && a_in_ready) a_wr_cnt <= a_wr_cnt + 1;
         if (a_m_out_valid && a_out_ready) a_rd_cnt <= a_rd_cnt + 1;
      end
      if (pre_we) mem_a[pre_idx] <= pre_data;
      else if (!reset && a_m_in_valid && a_in_ready) mem_a[a_m_in_addr[7:2]] <= a_m_in_data;
   end

   assign a_m_out_data = a_out_ready ? mem_a[a_m_out_addr[7:2]] : 32'hBAD0_BAD0;
   assign b_m_out_data = b_out_ready ? mem_a[b_m_out_addr[7:2]] : 32'hBAD0_BAD0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      a_p0_req = 0; a_p0_addr = 0; a_p1_req = 0; a_p1_we = 0; a_p1_addr = 0; a_p1_wdata = 0;
      b_p0_req = 0; b_p0_addr = 0; b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;
      tick; tick;

      // Reset state
      chk("rst_m_in_valid", 32'(a_m_in_valid), 32'd0);
      chk("rst_m_out_valid", 32'(a_m_out_valid), 32'd0);
      chk("rst_p0_done", 32'(a_p0_done), 32'd0);
      chk("rst_p1_done", 32'(a_p1_done), 32'd0);
      chk("rst_addrs", a_m_in_addr | a_m_in_data | a_m_out_addr, 32'd0);
      chk("rst_rdata", a_p0_rdata | a_p1_rdata, 32'd0);
      reset = 1'b0;
      pre_we = 1'b1; pre_idx = 6'd4; pre_data = 32'hDEAD_BEEF;
      tick;
      pre_we = 1'b0;

      // Port 0 alone (cycle 0 = now)
      a_p0_req = 1'b1; a_p0_addr = 32'h10;
      tick;
      chk("p0_c1_out_valid", 32'(a_m_out_valid), 32'd1);
      chk("p0_c1_in_valid", 32'(a_m_in_valid), 32'd0);
      chk("p0_c1_out_addr", a_m_out_addr, 32'h10);
      tick;
      chk("p0_c2_done", 32'(a_p0_done), 32'd0);
      tick;
      chk("p0_c3_done", 32'(a_p0_done), 32'd1);
      chk("p0_c3_rdata", a_p0_rdata, 32'hDEAD_BEEF);
      chk("p0_c3_out_valid", 32'(a_m_out_valid), 32'd0);
      tick;
      a_p0_req = 1'b0;
      chk("p0_c4_done", 32'(a_p0_done), 32'd0);
      chk("p0_c4_no_regrant", 32'(a_m_out_valid), 32'd0);
      chk("p0_rd_cnt", 32'(a_rd_cnt), 32'd1);

      // Port 1 write then read (cycle 4 = now)
      a_p1_req = 1'b1; a_p1_we = 1'b1; a_p1_addr = 32'h20; a_p1_wdata = 32'h1234_5678;
      tick;
      chk("wr_in_valid", 32'(a_m_in_valid), 32'd1);
      chk("wr_out_valid", 32'(a_m_out_valid), 32'd0);
      chk("wr_in_addr", a_m_in_addr, 32'h20);
      chk("wr_in_data", a_m_in_data, 32'h1234_5678);
      tick; tick;
      chk("wr_done", 32'(a_p1_done), 32'd1);
      chk("wr_p1_rdata_held", a_p1_rdata, 32'd0);
      chk("wr_in_valid_low", 32'(a_m_in_valid), 32'd0);
      tick;
      a_p1_we = 1'b0;
      tick;
      chk("rd_out_valid", 32'(a_m_out_valid), 32'd1);
      chk("rd_in_valid", 32'(a_m_in_valid), 32'd0);
      tick; tick;
      chk("rd_done", 32'(a_p1_done), 32'd1);
      chk("rd_p1_rdata", a_p1_rdata, 32'h1234_5678);
      chk("rd_p0_rdata_held", a_p0_rdata, 32'hDEAD_BEEF);
      chk("wr_cnt", 32'(a_wr_cnt), 32'd1);

      // Round-robin contention from cycle 12
      tick;
      a_p0_req = 1'b1; a_p0_addr = 32'h10;
      for (int k = 13; k <= 24; k++) begin
         tick;
         chk($sformatf("rr_p0_done_c%0d", k), 32'(a_p0_done), 32'(k == 15 || k == 21));
         chk($sformatf("rr_p1_done_c%0d", k), 32'(a_p1_done), 32'(k == 18 || k == 24));
         if (k == 16) chk("rr_c16_addr", a_m_out_addr, 32'h20);
         if (k == 18) chk("rr_p1_rdata", a_p1_rdata, 32'h1234_5678);
         if (k == 22) a_p0_req = 1'b0;
      end
      tick;
      a_p1_req = 1'b0;
      chk("rr_c25_idle", 32'(a_m_out_valid), 32'd0);
      chk("rr_rd_cnt", 32'(a_rd_cnt), 32'd6);

      // Fixed priority on B: port 0 alone, then a tie with last_grant = port 0
      b_p0_req = 1'b1; b_p0_addr = 32'h10;
      tick; tick; tick;
      chk("fp_solo_done", 32'(b_p0_done), 32'd1);
      chk("fp_solo_rdata", b_p0_rdata, 32'hDEAD_BEEF);
      tick;
      b_p1_req = 1'b1; b_p1_we = 1'b0; b_p1_addr = 32'h20;
      tick;
      chk("fp_tie_addr", b_m_out_addr, 32'h10);
      for (int k = 6; k <= 17; k++) begin
         tick;
         chk($sformatf("fp_p0_done_s%0d", k), 32'(b_p0_done), 32'(k == 7 || k == 13));
         chk($sformatf("fp_p1_done_s%0d", k), 32'(b_p1_done), 32'(k == 10 || k == 16));
         if (k == 10) chk("fp_p1_rdata", b_p1_rdata, 32'h1234_5678);
         if (k == 14) b_p0_req = 1'b0;
         if (k == 17) begin
            chk("fp_s17_idle", 32'(b_m_out_valid), 32'd0);
            b_p1_req = 1'b0;
         end
      end

      // Reset during a port 1 write on A
      a_p1_req = 1'b1; a_p1_we = 1'b1; a_p1_addr = 32'h30; a_p1_wdata = 32'hCAFE_F00D;
      tick;
      chk("rb_in_valid", 32'(a_m_in_valid), 32'd1);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0; a_p1_req = 1'b0;
      chk("rb_in_valid_low", 32'(a_m_in_valid), 32'd0);
      chk("rb_out_valid_low", 32'(a_m_out_valid), 32'd0);
      chk("rb_dones_low", 32'({a_p0_done, a_p1_done}), 32'd0);
      chk("rb_rdata_cleared", a_p0_rdata | a_p1_rdata, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("rb_no_done", 32'(a_p1_done), 32'd0);
      end
      chk("rb_wr_cnt", 32'(a_wr_cnt), 32'd1);
      a_p0_req = 1'b1; a_p0_addr = 32'h10;
      a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 32'h20;
      tick;
      chk("rb_tie_valid", 32'(a_m_out_valid), 32'd1);
      chk("rb_tie_addr", a_m_out_addr, 32'h10);
      tick; tick;
      chk("rb_p0_done", 32'(a_p0_done), 32'd1);
      chk("rb_p1_not_done", 32'(a_p1_done), 32'd0);
      chk("rb_p0_rdata", a_p0_rdata, 32'hDEAD_BEEF);
      tick;
      a_p0_req = 1'b0;
      tick; tick;
      chk("rb_p1_done", 32'(a_p1_done), 32'd1);
      chk("rb_p1_rdata", a_p1_rdata, 32'h1234_5678);
      tick;
      a_p1_req = 1'b0;
      tick;

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
